// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: datapath widths, XZR index and the writeback trace event.
// Macro WB_TRACE_PC_EN adds a pc field to each traced event.
package legv8_pkg;

  localparam int unsigned WORD       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SEQ_W      = 16;

  localparam logic [REG_ADDR_W-1:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_idx;
    logic [WORD-1:0]       data;
    logic [SEQ_W-1:0]      seq;
`ifdef WB_TRACE_PC_EN
    logic [WORD-1:0]       pc;
`endif
  } wb_event_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is visible whenever valid_o is high.
// Full-with-pop accepts a push; the pointers carry one extra MSB to tell full from empty.
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_c;
  logic          empty_c;
  logic          pop_ok_c;
  logic          push_ok_c;

  assign count_c   = wr_ptr_q - rd_ptr_q;
  assign empty_c   = (count_c == '0);
  assign full_o    = (count_c == CW'(DEPTH));
  assign valid_o   = ~empty_c;
  assign count_o   = count_c;
  assign pop_ok_c  = pop_i & ~empty_c;
  assign push_ok_c = push_i & (~full_o | pop_ok_c);

  // Empty FIFO presents zeros so stale storage never leaks onto the head fields.
  assign rdata_o = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + CW'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok_c && !clr_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: filters XZR writes, stamps sequence numbers, tracks drops.
// Macro WB_TRACE_PC_EN adds wb_pc/out_pc ports carried through the FIFO with each event.
module wb_trace_buffer
  import legv8_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WORD  = legv8_pkg::WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [4:0]               wb_reg,
  input  logic [WORD-1:0]          wb_data,
`ifdef WB_TRACE_PC_EN
  input  logic [WORD-1:0]          wb_pc,
  output logic [WORD-1:0]          out_pc,
`endif
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_reg,
  output logic [WORD-1:0]          out_data,
  output logic [15:0]              out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned EW = $bits(wb_event_t);

  logic [15:0] seq_q, seq_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;

  logic        qual_c;
  logic        pop_c;
  logic        drop_c;
  logic        full_c;
  wb_event_t   ev_in_c;
  wb_event_t   ev_head_c;
  logic [EW-1:0] head_bits_c;

  assign qual_c = wb_en && (wb_reg != XZR_IDX);
  assign pop_c  = out_valid && out_ready;
  assign drop_c = qual_c && full_c && !pop_c;

  always_comb begin
    ev_in_c         = '0;
    ev_in_c.reg_idx = wb_reg;
    ev_in_c.data    = wb_data;
    ev_in_c.seq     = seq_q;
`ifdef WB_TRACE_PC_EN
    ev_in_c.pc      = wb_pc;
`endif
  end

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .push_i  (qual_c),
    .pop_i   (out_ready),
    .wdata_i (ev_in_c),
    .rdata_o (head_bits_c),
    .valid_o (out_valid),
    .full_o  (full_c),
    .count_o (count)
  );

  assign ev_head_c = wb_event_t'(head_bits_c);
  assign out_reg   = ev_head_c.reg_idx;
  assign out_data  = ev_head_c.data;
  assign out_seq   = ev_head_c.seq;
`ifdef WB_TRACE_PC_EN
  assign out_pc    = ev_head_c.pc;
`endif

  // Dropped events still consume a sequence number so gaps reveal the loss.
  always_comb begin
    seq_d      = seq_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clr) begin
      seq_d      = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (qual_c) seq_d = seq_q + 16'd1;
      if (drop_c) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (DEPTH=8, WORD=64); pc ports follow WB_TRACE_PC_EN.
module tb_wb_trace_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WORD  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_en;
  logic [4:0]        wb_reg;
  logic [WORD-1:0]   wb_data;
  logic              clr;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_reg;
  logic [WORD-1:0]   out_data;
  logic [15:0]       out_seq;
  logic [3:0]        count;
  logic              overflow;
  logic [15:0]       drop_cnt;
`ifdef WB_TRACE_PC_EN
  logic [WORD-1:0]   wb_pc;
  logic [WORD-1:0]   out_pc;
`endif

  int checks = 0;
  int errors = 0;

  wb_trace_buffer #(.DEPTH(DEPTH), .WORD(WORD)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
`ifdef WB_TRACE_PC_EN
    .wb_pc     (wb_pc),
    .out_pc    (out_pc),
`endif
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_reg   (out_reg),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".count"}, 64'(count), 64'd0);
  endtask

  task automatic chk_head(input string tag, input logic [4:0] r, input logic [63:0] d, input logic [15:0] s);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".reg"},   64'(out_reg),   64'(r));
    chk({tag, ".data"},  out_data,       d);
    chk({tag, ".seq"},   64'(out_seq),   64'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_reg = '0; wb_data = '0; clr = 1'b0; out_ready = 1'b0;
`ifdef WB_TRACE_PC_EN
    wb_pc = '0;
`endif
    #1;
    chk_empty("reset");
    chk("reset.overflow", 64'(overflow), 64'd0);
    chk("reset.drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset.out_reg",  64'(out_reg),  64'd0);
    chk("reset.out_data", out_data,      64'd0);
    chk("reset.out_seq",  64'(out_seq),  64'd0);
    step();
    rst = 1'b0;

    // First event visible the cycle after capture
    wb_en = 1'b1; wb_reg = 5'd9; wb_data = 64'h1;
    step();
    wb_en = 1'b0;
    chk_head("first", 5'd9, 64'h1, 16'd0);
    chk("first.count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_empty("first_pop");

    // Fresh reset so the XZR case starts from seq 0
    rst = 1'b1; step(); rst = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd31; wb_data = 64'h55;
    step();
    wb_en = 1'b0;
    chk_empty("xzr");
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 64'h7;
    step();
    wb_en = 1'b0;
    chk_head("after_xzr", 5'd3, 64'h7, 16'd0);
    clr = 1'b1; step(); clr = 1'b0;
    chk_empty("clr_idle");

    // Ten events into an 8-deep buffer with no consumer
    for (int i = 1; i <= 10; i++) begin
      wb_en = 1'b1; wb_reg = 5'(i); wb_data = 64'(i);
      step();
    end
    wb_en = 1'b0;
    chk("ovf.count",    64'(count),    64'd8);
    chk("ovf.drop_cnt", 64'(drop_cnt), 64'd2);
    chk("ovf.overflow", 64'(overflow), 64'd1);
    chk_head("ovf.head", 5'd1, 64'd1, 16'd0);
    step();
    chk_head("stall.head", 5'd1, 64'd1, 16'd0);

    // Full with simultaneous push and pop: push accepted, no drop
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'h99; out_ready = 1'b1;
    step();
    wb_en = 1'b0; out_ready = 1'b0;
    chk("fullpp.count",    64'(count),    64'd8);
    chk("fullpp.drop_cnt", 64'(drop_cnt), 64'd2);
    for (int k = 0; k < 8; k++) begin
      if (k < 7) chk_head($sformatf("drain%0d", k), 5'(k + 2), 64'(k + 2), 16'(k + 1));
      else       chk_head("drain_tail", 5'd5, 64'h99, 16'd10);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk_empty("drained");
    chk("drained.overflow", 64'(overflow), 64'd1);

    // Ready while empty does nothing
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk_empty("ready_empty");

    // Clear wins over a same-cycle push
    wb_en = 1'b1; wb_reg = 5'd4; wb_data = 64'h44; clr = 1'b1;
    step();
    wb_en = 1'b0; clr = 1'b0;
    chk_empty("clr_push");
    chk("clr_push.overflow", 64'(overflow), 64'd0);
    chk("clr_push.drop_cnt", 64'(drop_cnt), 64'd0);

    // Push and pop while empty: push lands, pop ignored
    wb_en = 1'b1; wb_reg = 5'd6; wb_data = 64'h66; out_ready = 1'b1;
    step();
    wb_en = 1'b0; out_ready = 1'b0;
    chk_head("empty_pp", 5'd6, 64'h66, 16'd0);
    chk("empty_pp.count", 64'(count), 64'd1);

    // Asynchronous reset with events buffered
    for (int i = 1; i <= 2; i++) begin
      wb_en = 1'b1; wb_reg = 5'(i); wb_data = 64'(i);
      step();
    end
    wb_en = 1'b0;
    chk("pre_rst.count", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk_empty("async_rst");
    chk("async_rst.out_data", out_data, 64'd0);
    step();
    rst = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd2; wb_data = 64'h2;
    step();
    wb_en = 1'b0;
    chk_head("post_rst", 5'd2, 64'h2, 16'd0);
    chk("post_rst.count", 64'(count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning event FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter WORD, default 64, meaning writeback data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port wb_en, input, 1, the CPU writeback stage asserts register write this cycle.
REQ-007 SHALL have port wb_reg, input, 5, the destination register index.
REQ-008 SHALL have port wb_data, input, WORD, the writeback data.
REQ-009 SHALL have port clr, input, 1, synchronous flush of FIFO, counters and flags.
REQ-010 SHALL have port out_valid, output, 1, head event available.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the head event.
REQ-012 SHALL have port out_reg, output, 5, the head event register index.
REQ-013 SHALL have port out_data, output, WORD, the head event data.
REQ-014 SHALL have port out_seq, output, 16, the head event sequence number.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1, the current occupancy.
REQ-016 SHALL have port overflow, output, 1, a sticky flag meaning an event was dropped.
REQ-017 SHALL have port drop_cnt, output, 16, the number of dropped events.

Function
REQ-018 SHALL capture one event on each rising clk where wb_en=1 and wb_reg!=31; writes to XZR (31) SHALL be ignored and SHALL NOT consume a sequence number.
REQ-019 SHALL assign each captured or dropped event a sequence number from a 16-bit counter that starts at 0, increments by 1 per qualifying event, and wraps 0xFFFF->0.
REQ-020 SHALL be a show-ahead FIFO: an event pushed at edge N drives out_valid=1 and its fields after edge N, so it is visible in cycle N+1.
REQ-021 SHALL pop the head on a rising edge with out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-022 SHALL keep out_reg, out_data and out_seq stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drop a qualifying event when full with no pop in the same cycle: FIFO unchanged, overflow set to 1, drop_cnt incremented, saturating at 0xFFFF.
REQ-024 SHALL accept the push on a simultaneous push and pop while full; count stays DEPTH and nothing is dropped.
REQ-025 SHALL perform both operations on a simultaneous push and pop while empty: the pushed event becomes the head at the next cycle and count ends at 1.
REQ-026 SHALL give clr priority over push and pop in the same cycle: the FIFO empties, and seq, drop_cnt and overflow go to 0.
REQ-027 SHALL manage the pointers with wrap-around modulo DEPTH, with count = push_ptr - pop_ptr using the extra MSB.

Reset
REQ-028 SHALL, on rst=1 and regardless of clk: out_valid=0, count=0, overflow=0, drop_cnt=0, seq counter=0, pointers=0, out_reg=0, out_data=0, out_seq=0.
REQ-029 SHALL, when rst is asserted mid-operation, discard all buffered events with no output glitch other than going to the reset values; the first edge after release SHALL behave as from reset.

Configuration
REQ-030 SHALL, with macro WB_TRACE_PC_EN defined, add port wb_pc (input, WORD) and out_pc (output, WORD) stored per entry with identical timing.
REQ-031 SHALL, without WB_TRACE_PC_EN, have no pc ports and no pc storage.

Structure
REQ-032 SHALL take WORD, REG_ADDR_W=5, XZR_IDX=31 and the wb_event_t struct {reg, data, seq[, pc]} from the shared legv8_pkg.
REQ-033 SHALL place storage in one sub-module, wb_trace_fifo (generic show-ahead sync FIFO); wb_trace_buffer SHALL hold the filtering, sequencing and drop logic.

Verification
REQ-034 SHALL verify this case: reset, then wb_en with reg 9, data 0x1 -> next cycle out_valid=1, out_reg=9, out_data=0x1, out_seq=0, count=1.
REQ-035 SHALL verify this case: wb_en with reg 31, data 0x55 -> out_valid remains 0, and the next valid event carries seq 0.
REQ-036 SHALL verify this case: out_ready=0, then 10 events with data 1..10 and DEPTH=8 -> count=8, drop_cnt=2, overflow=1; draining yields data 1..8 with seq 0..7.
REQ-037 SHALL verify this case: full with push data 0x99 and pop in the same cycle -> count=8, drop_cnt unchanged, tail entry data 0x99.
REQ-038 SHALL verify this case: clr in the same cycle as a push -> count=0, out_valid=0, overflow=0, and the next event gets seq 0.
REQ-039 SHALL verify this case: rst pulsed with 3 events buffered -> immediate out_valid=0 and count=0; afterwards push reg 2, data 0x2 -> out_seq=0.
